posit_pio_bridge: RTL
=====================

# posit_pio_bridge

Sequencing stage between the HPS PIO operand exports and the posit arithmetic core. It registers the two 32-bit operands written by software and detects when either one changes. It then launches exactly one operation on the posit core over a valid/ready handshake and returns the core's result on the PIO result export. Software writes operands and polls the result; the bridge provides ordering, back-pressure handling and the completion count.

## Interface
Parameters:
- WIDTH, 32, posit word width (operands and result)
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT; only used when the watchdog is compiled in

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; connects to hps_fpga_reset
- num1  in  WIDTH  operand A from PIO num1 export
- num2  in  WIDTH  operand B from PIO num2 export
- result  out  WIDTH  last completed result, to PIO result export
- core_in_valid  out  1  operand pair valid to posit core
- core_in_ready  in  1  core accepts operands
- core_num1 / core_num2  out  WIDTH  snapshot operands to core
- core_out_valid  in  1  core result valid
- core_out_result  in  WIDTH  core result
- core_out_ready  out  1  bridge accepts result
- busy  out  1  high in ISSUE or WAIT
- done_count  out  8  completed-operation counter, wraps 255→0
- timeout_flag  out  1  sticky watchdog flag; constant 0 when the watchdog is compiled out

## Operation
- Input registers: num_q ← {num1, num2} every cycle.
- Snapshot registers: snap ← num_q at each launch. Operand change is num_q ≠ snap.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: on change, load snap, go to ISSUE.
  - ISSUE: core_in_valid = 1, core_numX = snap. Held stable until core_in_ready; the handshake edge moves to WAIT.
  - WAIT: core_out_ready = 1. On core_out_valid: result ← core_out_result, done_count++, go to IDLE.
- core_out_ready is also 1 in IDLE, so stray core results are drained and discarded. result does not change in IDLE.
- Operands changed during ISSUE or WAIT:
  - The in-flight operation completes and its result is published.
  - IDLE then sees the mismatch and relaunches with the latest num_q.
  - Intermediate values that never persist through IDLE are skipped.
- Both operands changing in the same cycle gives a single launch.
- Writing an operand back to its current snap value gives no launch.
- Reset, including mid-operation: state IDLE, num_q = snap = 0, result 0, done_count 0, timeout_flag 0, all core handshake outputs 0. Any in-flight core transaction is abandoned. Operands 0/0 after reset do not launch.

## Timing
- Operand settles before edge E0. num_q updates at E0; at E1 snap loads and the state enters ISSUE, so core_in_valid is high after E1.
- With core_in_ready = 1, the handshake occurs at E2, giving WAIT after E2.
- If core_out_valid is high in the cycle after E2, result updates at E3.
- Minimum operand-to-result latency is 3 edges plus core latency.
- Each back-pressure cycle on core_in_ready adds 1 cycle.
- busy rises with ISSUE and falls in the same cycle result updates.
- done_count and result update on the same edge.

## Configuration
- POSIT_BRIDGE_WATCHDOG_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without core_out_valid: result ← 0x8000_0000 (NaR), timeout_flag ← 1 (sticky until reset), done_count++, go to IDLE.
  - Simultaneous valid and expiry: the core result wins and no timeout is taken.
- Undefined: WAIT waits indefinitely, there is no counter, and timeout_flag is tied to 0.

## Structure
- Package posit_bridge_pkg holds:
  - state enum (IDLE/ISSUE/WAIT)
  - POSIT_WIDTH = 32
  - POSIT_NAR = 32'h8000_0000
  - DONE_CNT_W = 8
- One sub-module, posit_bridge_watchdog: counter with clear, enable and expiry output, instantiated only under POSIT_BRIDGE_WATCHDOG_EN.

## Test plan
- Reset, then num1 = 0x4000_0000 (1.0) and num2 = 0x4000_0000, core returns 0x4800_0000 after 4 cycles, core_in_ready = 1 → exactly one launch; result = 0x4800_0000 on core_out_valid edge + 1; done_count = 1.
- Hold core_in_ready = 0 for 5 cycles → core_in_valid stays high with stable core_num1/num2; handshake occurs on the 6th cycle.
- Change num2 during WAIT → first result published, then a second launch with the new num2; done_count = 2.
- Change num1 and num2 in the same cycle, and write an unchanged value → one launch, then zero launches.
- Assert reset during WAIT → all outputs 0 asynchronously; a late core_out_valid is drained with result still 0.
- POSIT_BRIDGE_WATCHDOG_EN with TIMEOUT_CYCLES = 16 and core silent → result = 0x8000_0000 after 16 WAIT cycles; timeout_flag = 1; done_count = 1.

Source files
------------

// File: rtl/posit_bridge_pkg.sv
// Shared types and constants for the HPS PIO to posit-core bridge.
package posit_bridge_pkg;

    localparam int          POSIT_WIDTH = 32;
    localparam logic [31:0] POSIT_NAR   = 32'h8000_0000;
    localparam int          DONE_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/posit_bridge_watchdog.sv
// WAIT-state watchdog: counts cycles while enabled, cleared on each new launch.
module posit_bridge_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // cnt_q holds the number of WAIT cycles already elapsed, so this fires in the LIMIT-th one.
    assign expired_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/posit_pio_bridge.sv
// Launches one posit-core operation per operand change and publishes the result.
// Optional WAIT watchdog is compiled in with POSIT_BRIDGE_WATCHDOG_EN.
module posit_pio_bridge
    import posit_bridge_pkg::*;
#(
    parameter int WIDTH          = POSIT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      num1,
    input  logic [WIDTH-1:0]      num2,
    output logic [WIDTH-1:0]      result,
    output logic                  core_in_valid,
    input  logic                  core_in_ready,
    output logic [WIDTH-1:0]      core_num1,
    output logic [WIDTH-1:0]      core_num2,
    input  logic                  core_out_valid,
    input  logic [WIDTH-1:0]      core_out_result,
    output logic                  core_out_ready,
    output logic                  busy,
    output logic [DONE_CNT_W-1:0] done_count,
    output logic                  timeout_flag
);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        num1_q, num2_q;
    logic [WIDTH-1:0]        snap1_q, snap1_d, snap2_q, snap2_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic [DONE_CNT_W-1:0]   done_q, done_d;
    logic                    timeout_q, timeout_d;
    logic                    changed, wdog_exp;

`ifdef POSIT_BRIDGE_WATCHDOG_EN
    localparam logic [WIDTH-1:0] NAR = {1'b1, {(WIDTH-1){1'b0}}};

    posit_bridge_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q == ISSUE && core_in_ready),
        .en_i      (state_q == WAIT),
        .expired_o (wdog_exp)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign wdog_exp   = 1'b0;
`endif

    assign changed = (num1_q != snap1_q) || (num2_q != snap2_q);

    always_comb begin
        state_d   = state_q;
        snap1_d   = snap1_q;
        snap2_d   = snap2_q;
        result_d  = result_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (changed) begin
                    snap1_d = num1_q;
                    snap2_d = num2_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (core_in_ready) state_d = WAIT;
            end
            WAIT: begin
                // A core result arriving on the expiry cycle takes priority over the timeout.
                if (core_out_valid) begin
                    result_d = core_out_result;
                    done_d   = done_q + 1'b1;
                    state_d  = IDLE;
                end else if (wdog_exp) begin
`ifdef POSIT_BRIDGE_WATCHDOG_EN
                    result_d  = NAR;
`endif
                    timeout_d = 1'b1;
                    done_d    = done_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            num1_q    <= '0;
            num2_q    <= '0;
            snap1_q   <= '0;
            snap2_q   <= '0;
            result_q  <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num1_q    <= num1;
            num2_q    <= num2;
            snap1_q   <= snap1_d;
            snap2_q   <= snap2_d;
            result_q  <= result_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Ready in IDLE too so stray core results are drained; held low while in reset.
    assign core_out_ready = !reset && (state_q != ISSUE);
    assign core_in_valid  = (state_q == ISSUE);
    assign core_num1      = snap1_q;
    assign core_num2      = snap2_q;
    assign busy           = (state_q != IDLE);
    assign result         = result_q;
    assign done_count     = done_q;
    assign timeout_flag   = timeout_q;

endmodule
